weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameters SHALL be: KERNEL_SIZE, default 3, kernel edge length; ROM_ADDRESS_DATAWIDTH, default 12, weight-memory address width; NUMBER_DATAWIDTH, default 16, weight word width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle load request, sampled in IDLE and DONE only.
REQ-005 abort  input  1  synchronous cancel, honoured in every state.
REQ-006 num_kernels  input  ROM_ADDRESS_DATAWIDTH  kernel count for this load, latched on accepted start.
REQ-007 s_valid  input  1  upstream weight word valid.
REQ-008 s_data  input  NUMBER_DATAWIDTH  upstream weight word.
REQ-009 s_ready  output  1  loader accepts a word this cycle.
REQ-010 mem_we  output  1  weight-memory write strobe.
REQ-011 mem_addr  output  ROM_ADDRESS_DATAWIDTH  weight-memory write address.
REQ-012 mem_din  output  NUMBER_DATAWIDTH  weight-memory write data.
REQ-013 kernel_done  output  1  one-cycle pulse when a full kernel (KERNEL_SIZE*KERNEL_SIZE words) has been written.
REQ-014 load_done  output  1  level; all requested kernels written.
REQ-015 overflow  output  1  sticky; write address wrapped during this load.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, DONE; all outputs registered.
REQ-017 IDLE: start=1 with num_kernels!=0 -> LOAD; start=1 with num_kernels==0 -> DONE; write pointer, element counter, kernel counter, overflow cleared on that edge.
REQ-018 s_ready SHALL be 1 exactly while state==LOAD, 0 in IDLE and DONE.
REQ-019 A word is accepted only when s_valid=1 and s_ready=1 on the same rising edge.
REQ-020 Each accepted word SHALL produce mem_we=1 on the following cycle with mem_din=accepted s_data and mem_addr=write pointer value at acceptance; latency exactly 1 cycle.
REQ-021 mem_we SHALL be 0 in any cycle not following an acceptance; mem_addr and mem_din hold their last values when mem_we=0.
REQ-022 Write pointer SHALL increment by 1 per accepted word; first word of a load goes to address 0.
REQ-023 Element counter counts 0..KERNEL_SIZE*KERNEL_SIZE-1 per accepted word and wraps to 0 after the last element.
REQ-024 kernel_done SHALL pulse high in the same cycle as the mem_we of each kernel's last element; the kernel counter increments on the same edge.
REQ-025 When the accepted word is the last element of kernel num_kernels, the state SHALL go LOAD -> DONE on that edge, so no further word is accepted.
REQ-026 DONE: load_done=1, and it holds until leaving DONE; start=1 in DONE SHALL begin a new load exactly as from IDLE.
REQ-027 start in LOAD SHALL be ignored.
REQ-028 Write pointer at 2^ROM_ADDRESS_DATAWIDTH-1 with another word accepted SHALL wrap to 0 and set overflow; overflow remains set until the next accepted start, abort or reset.
REQ-029 abort=1 SHALL force IDLE on the next edge from any state and clear the counters, overflow and load_done; a word presented in the abort cycle is not accepted (s_ready deasserts next cycle, no mem_we follows).
REQ-030 If start and abort are both high in the same cycle, abort SHALL win.
REQ-031 s_valid/s_data are don't-care while s_ready=0; stalls (s_valid=0) in LOAD SHALL hold all counters.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE with s_ready, mem_we, kernel_done, load_done and overflow at 0 and mem_addr, mem_din and all counters at 0.
REQ-033 Reset mid-LOAD SHALL discard the partial load; after release the block waits in IDLE for start.

Verification
REQ-034 num_kernels=2, start, 18 back-to-back words 0x0001..0x0012 -> mem_we on 18 consecutive cycles at addr 0..17 with matching data; kernel_done pulses with addr 8 and addr 17; load_done=1 the cycle after the last write; s_ready=0 from then on.
REQ-035 num_kernels=1 with s_valid toggling every other cycle -> exactly 9 writes at addr 0..8; counters hold during gaps; one kernel_done pulse.
REQ-036 num_kernels=0, start -> DONE next cycle with load_done=1; no mem_we and no kernel_done.
REQ-037 abort asserted after 5 accepted words, with s_valid=1 -> mem_we for words 1-5 only; IDLE; load_done=0; a new start writes from addr 0.
REQ-038 ROM_ADDRESS_DATAWIDTH=4, num_kernels=2 (18 words) -> addresses 0..15 then 0,1; overflow=1 from the write to addr 0 onward; load_done=1 at the end.
REQ-039 reset pulsed low mid-LOAD after 4 words -> all outputs 0 immediately; after release s_ready=0 until start.

Source files
------------

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams kernel weight words from an upstream source into weight memory
//
// Purpose: accepts num_kernels * KERNEL_SIZE^2 weight words over a valid/ready
// handshake and writes each one to consecutive weight-memory addresses,
// starting at address 0, one cycle after it is accepted.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   start        load request, honoured in IDLE and DONE
//   abort        synchronous cancel, wins over start
//   num_kernels  kernel count, latched when start is accepted
//   s_valid      upstream word valid
//   s_data       upstream weight word
//   s_ready      loader accepts a word this cycle
//   mem_we       weight-memory write strobe
//   mem_addr     weight-memory write address
//   mem_din      weight-memory write data
//   kernel_done  pulse with the write of each kernel's last element
//   load_done    level while all requested kernels are written
//   overflow     sticky, write address wrapped during this load
module weight_loader #(
    parameter int KERNEL_SIZE           = 3,
    parameter int ROM_ADDRESS_DATAWIDTH = 12,
    parameter int NUMBER_DATAWIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ROM_ADDRESS_DATAWIDTH-1:0] num_kernels,
    input  logic                             s_valid,
    input  logic [NUMBER_DATAWIDTH-1:0]      s_data,
    output logic                             s_ready,
    output logic                             mem_we,
    output logic [ROM_ADDRESS_DATAWIDTH-1:0] mem_addr,
    output logic [NUMBER_DATAWIDTH-1:0]      mem_din,
    output logic                             kernel_done,
    output logic                             load_done,
    output logic                             overflow
);

    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int EW = $clog2(KK + 1);
    localparam logic [EW-1:0] ELEM_LAST = EW'(KK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                             state_q, state_d;
    logic [ROM_ADDRESS_DATAWIDTH-1:0]   wptr_q;
    logic [ROM_ADDRESS_DATAWIDTH-1:0]   kcnt_q;
    logic [ROM_ADDRESS_DATAWIDTH-1:0]   nk_q;
    logic [EW-1:0]                      elem_q;
    logic                               s_ready_q;
    logic                               mem_we_q;
    logic [ROM_ADDRESS_DATAWIDTH-1:0]   mem_addr_q;
    logic [NUMBER_DATAWIDTH-1:0]        mem_din_q;
    logic                               kernel_done_q;
    logic                               load_done_q;
    logic                               overflow_q;

    logic accept;
    logic start_ok;
    logic last_elem;
    logic last_kernel;
    logic first_word;

    // s_ready_q is high exactly while in LOAD, so it doubles as the state gate.
    assign accept      = s_valid && s_ready_q && !abort;
    assign start_ok    = start && !abort && (state_q != LOAD);
    assign last_elem   = (elem_q == ELEM_LAST);
    assign last_kernel = (kcnt_q == nk_q - 1'b1);
    // Counters are cleared together with the pointer, so the pointer is back at
    // zero with a non-zero count only after it has wrapped.
    assign first_word  = (elem_q == '0) && (kcnt_q == '0);

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = (num_kernels == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (accept && last_elem && last_kernel) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            kcnt_q        <= '0;
            nk_q          <= '0;
            elem_q        <= '0;
            s_ready_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            kernel_done_q <= 1'b0;
            load_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= (state_d == LOAD);
            load_done_q   <= (state_d == DONE);
            mem_we_q      <= 1'b0;
            kernel_done_q <= 1'b0;
            if (abort) begin
                wptr_q     <= '0;
                kcnt_q     <= '0;
                nk_q       <= '0;
                elem_q     <= '0;
                overflow_q <= 1'b0;
            end else if (start_ok) begin
                wptr_q     <= '0;
                kcnt_q     <= '0;
                nk_q       <= num_kernels;
                elem_q     <= '0;
                overflow_q <= 1'b0;
            end else if (accept) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= wptr_q;
                mem_din_q  <= s_data;
                wptr_q     <= wptr_q + 1'b1;
                if ((wptr_q == '0) && !first_word) begin
                    overflow_q <= 1'b1;
                end
                if (last_elem) begin
                    elem_q        <= '0;
                    kcnt_q        <= kcnt_q + 1'b1;
                    kernel_done_q <= 1'b1;
                end else begin
                    elem_q <= elem_q + 1'b1;
                end
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign kernel_done = kernel_done_q;
    assign load_done   = load_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - self-checking bench for weight_loader
module tb_weight_loader;

    localparam int KS   = 3;
    localparam int KK   = KS * KS;
    localparam int DW   = 16;
    localparam int AW_A = 12;
    localparam int AW_B = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic [AW_A-1:0] nk;

    logic            rdy_a, we_a, kd_a, ld_a, ov_a;
    logic [AW_A-1:0] addr_a;
    logic [DW-1:0]   din_a;
    logic            rdy_b, we_b, kd_b, ld_b, ov_b;
    logic [AW_B-1:0] addr_b;
    logic [DW-1:0]   din_b;

    always #5 clk = ~clk;

    weight_loader #(.KERNEL_SIZE(KS), .ROM_ADDRESS_DATAWIDTH(AW_A), .NUMBER_DATAWIDTH(DW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_kernels(nk),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_a), .mem_we(we_a),
        .mem_addr(addr_a), .mem_din(din_a), .kernel_done(kd_a), .load_done(ld_a),
        .overflow(ov_a)
    );

    weight_loader #(.KERNEL_SIZE(KS), .ROM_ADDRESS_DATAWIDTH(AW_B), .NUMBER_DATAWIDTH(DW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_kernels(nk[AW_B-1:0]),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_din(din_b), .kernel_done(kd_b), .load_done(ld_b),
        .overflow(ov_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a load is "accept words until count reaches nk*KK";
    // word k goes to address k mod 2^AW, ends a kernel when (k+1) mod KK == 0,
    // and carries overflow once k >= 2^AW.
    int awid[2] = '{AW_A, AW_B};
    int m_mode[2];   // 0 idle, 1 loading, 2 done
    int m_cnt[2];
    int m_total[2];
    int e_we[2], e_addr[2], e_din[2], e_kd[2], e_ld[2], e_ov[2], e_rdy[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
            e_we[d] = 0; e_addr[d] = 0; e_din[d] = 0; e_kd[d] = 0;
            e_ld[d] = 0; e_ov[d] = 0; e_rdy[d] = 0;
        end
    endtask

    task automatic model_edge();
        int nkd;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            e_we[d] = 0;
            e_kd[d] = 0;
            if (abort) begin
                m_mode[d] = 0; m_cnt[d] = 0; e_ov[d] = 0;
            end else if (start && m_mode[d] != 1) begin
                nkd = int'(nk) & ((1 << awid[d]) - 1);
                m_total[d] = nkd * KK;
                m_cnt[d] = 0;
                e_ov[d] = 0;
                m_mode[d] = (nkd == 0) ? 2 : 1;
            end else if (m_mode[d] == 1 && s_valid) begin
                e_we[d]   = 1;
                e_addr[d] = m_cnt[d] % (1 << awid[d]);
                e_din[d]  = int'(s_data);
                if (m_cnt[d] >= (1 << awid[d])) e_ov[d] = 1;
                m_cnt[d]++;
                e_kd[d] = ((m_cnt[d] % KK) == 0) ? 1 : 0;
                if (m_cnt[d] == m_total[d]) m_mode[d] = 2;
            end
            e_rdy[d] = (m_mode[d] == 1) ? 1 : 0;
            e_ld[d]  = (m_mode[d] == 2) ? 1 : 0;
        end
    endtask

    task automatic compare();
        check_eq("a.s_ready",     32'(rdy_a),  e_rdy[0]);
        check_eq("a.mem_we",      32'(we_a),   e_we[0]);
        check_eq("a.mem_addr",    32'(addr_a), e_addr[0]);
        check_eq("a.mem_din",     32'(din_a),  e_din[0]);
        check_eq("a.kernel_done", 32'(kd_a),   e_kd[0]);
        check_eq("a.load_done",   32'(ld_a),   e_ld[0]);
        check_eq("a.overflow",    32'(ov_a),   e_ov[0]);
        check_eq("b.s_ready",     32'(rdy_b),  e_rdy[1]);
        check_eq("b.mem_we",      32'(we_b),   e_we[1]);
        check_eq("b.mem_addr",    32'(addr_b), e_addr[1]);
        check_eq("b.mem_din",     32'(din_b),  e_din[1]);
        check_eq("b.kernel_done", 32'(kd_b),   e_kd[1]);
        check_eq("b.load_done",   32'(ld_b),   e_ld[1]);
        check_eq("b.overflow",    32'(ov_b),   e_ov[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic st, input logic ab, input logic v, input logic [DW-1:0] data);
        start = st; abort = ab; s_valid = v; s_data = data;
        step();
    endtask

    task automatic begin_load(input int kernels);
        nk = AW_A'(kernels);
        drive(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; nk = '0;
        #1 reset = 1'b0;
        #1 model_reset();
        compare();
        repeat (2) step();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);

        // 2 kernels back to back; the 4-bit instance wraps after address 15
        begin_load(2);
        for (int i = 1; i <= 18; i++) drive(1'b0, 1'b0, 1'b1, DW'(i));
        repeat (3) drive(1'b0, 1'b0, 1'b1, 16'hdead);

        // 1 kernel with valid toggling, started from DONE
        begin_load(1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'(i % 2), DW'($urandom_range(0, 65535)));
        repeat (2) drive(1'b0, 1'b0, 1'b0, '0);

        // zero kernels goes straight to DONE
        begin_load(0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 16'h5555);

        // abort after 5 words with a word on the bus, then a fresh load
        begin_load(3);
        for (int i = 1; i <= 5; i++) drive(1'b0, 1'b0, 1'b1, DW'(16'h100 + i));
        drive(1'b0, 1'b1, 1'b1, 16'hbeef);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 16'hbeef);
        begin_load(1);
        for (int i = 1; i <= 10; i++) drive(1'b0, 1'b0, 1'b1, DW'(16'h200 + i));

        // asynchronous reset in the middle of a load
        begin_load(2);
        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b0, 1'b1, DW'(16'h300 + i));
        s_valid = 1'b1; s_data = 16'h3333;
        #2 reset = 1'b0;
        #1 model_reset();
        compare();
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 1'b1, 16'h4444);
        begin_load(1);
        for (int i = 1; i <= 9; i++) drive(1'b0, 1'b0, 1'b1, DW'(16'h400 + i));

        // random traffic: stray starts in LOAD, aborts, start+abort collisions
        for (int i = 0; i < 1500; i++) begin
            nk = AW_A'($urandom_range(0, 4));
            drive(1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 3) != 0),
                  DW'($urandom_range(0, 65535)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
